// File: rtl/rename_map_table.sv
// rename_map_table: architectural-register to ROB-tag rename map.
// Renames RENAME_WIDTH instructions per cycle with in-group bypass, clears
// busy bits for up to COMMIT_WIDTH retiring mappings per cycle, and (when
// RENAME_MAP_CKPT_EN is defined) keeps NUM_CKPT branch checkpoints that can
// be restored in a single cycle. Without RENAME_MAP_CKPT_EN recovery is by
// flush only and the checkpoint ports are ignored.
module rename_map_table #(
    parameter int ARCH_REG_INDEX_SIZE = 5,
    parameter int NUM_ARCH_REGS       = 32,
    parameter int ROB_ENTRY_WIDTH     = 5,
    parameter int RENAME_WIDTH        = 2,
    parameter int COMMIT_WIDTH        = 2,
    parameter int NUM_CKPT            = 4,
    parameter int CKPT_ID_W           = $clog2(NUM_CKPT)
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [RENAME_WIDTH-1:0]                              rn_valid,
    input  logic [RENAME_WIDTH-1:0][ARCH_REG_INDEX_SIZE-1:0]     rn_rs1,
    input  logic [RENAME_WIDTH-1:0][ARCH_REG_INDEX_SIZE-1:0]     rn_rs2,
    input  logic [RENAME_WIDTH-1:0][ARCH_REG_INDEX_SIZE-1:0]     rn_rd,
    input  logic [RENAME_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0]         rn_rob_id,
    output logic [RENAME_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0]         rs1_tag,
    output logic [RENAME_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0]         rs2_tag,
    output logic [RENAME_WIDTH-1:0]                              rs1_busy,
    output logic [RENAME_WIDTH-1:0]                              rs2_busy,
    input  logic [COMMIT_WIDTH-1:0]                              cm_valid,
    input  logic [COMMIT_WIDTH-1:0][ARCH_REG_INDEX_SIZE-1:0]     cm_rd,
    input  logic [COMMIT_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0]         cm_rob_id,
    input  logic                                                 flush,
    input  logic                                                 ckpt_save,
    output logic                                                 ckpt_free,
    output logic [CKPT_ID_W-1:0]                                 ckpt_alloc_id,
    input  logic                                                 ckpt_restore,
    input  logic [CKPT_ID_W-1:0]                                 ckpt_restore_id,
    input  logic                                                 ckpt_release,
    input  logic [CKPT_ID_W-1:0]                                 ckpt_release_id
);

    typedef logic [NUM_ARCH_REGS-1:0][ROB_ENTRY_WIDTH-1:0] tag_map_t;
    typedef logic [NUM_ARCH_REGS-1:0]                      busy_map_t;

    tag_map_t  tag_r;
    busy_map_t busy_r;
    tag_map_t  ren_tag_s;
    busy_map_t ren_hit_s;
    busy_map_t clr_s;
    tag_map_t  map_tag_s;
    busy_map_t map_busy_s;
    logic      restore_s;
    tag_map_t  rst_tag_s;
    busy_map_t rst_busy_s;

    // Registers whose busy bit a set of commits would clear, given the tag map
    // the commits are compared against.
    function automatic busy_map_t commit_clear(
        input tag_map_t                                          tags,
        input logic [COMMIT_WIDTH-1:0]                           valid,
        input logic [COMMIT_WIDTH-1:0][ARCH_REG_INDEX_SIZE-1:0]  rd,
        input logic [COMMIT_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0]      rob_id
    );
        busy_map_t clr;
        clr = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            for (int r = 1; r < NUM_ARCH_REGS; r++) begin
                clr[r] = clr[r] | (valid[j] && (rd[j] == ARCH_REG_INDEX_SIZE'(r))
                                   && (tags[r] == rob_id[j]));
            end
        end
        return clr;
    endfunction

    // Source lookup: map state, overridden by the youngest older slot in this
    // group writing the same register; x0 always reads as ready with tag 0.
    always_comb begin
        logic byp1_v;
        logic byp2_v;
        byp1_v = 1'b0;
        byp2_v = 1'b0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rs1_tag[i]  = tag_r[rn_rs1[i]];
            rs1_busy[i] = busy_r[rn_rs1[i]];
            rs2_tag[i]  = tag_r[rn_rs2[i]];
            rs2_busy[i] = busy_r[rn_rs2[i]];
            for (int p = 0; p < i; p++) begin
                byp1_v = rn_valid[p] && (rn_rd[p] != '0) && (rn_rd[p] == rn_rs1[i]);
                byp2_v = rn_valid[p] && (rn_rd[p] != '0) && (rn_rd[p] == rn_rs2[i]);
                rs1_tag[i]  = byp1_v ? rn_rob_id[p] : rs1_tag[i];
                rs1_busy[i] = rs1_busy[i] | byp1_v;
                rs2_tag[i]  = byp2_v ? rn_rob_id[p] : rs2_tag[i];
                rs2_busy[i] = rs2_busy[i] | byp2_v;
            end
            rs1_tag[i]  = (rn_rs1[i] == '0) ? '0 : rs1_tag[i];
            rs1_busy[i] = rs1_busy[i] & (rn_rs1[i] != '0);
            rs2_tag[i]  = (rn_rs2[i] == '0) ? '0 : rs2_tag[i];
            rs2_busy[i] = rs2_busy[i] & (rn_rs2[i] != '0);
        end
    end

    // Per-register rename result for this group; the highest slot wins.
    always_comb begin
        logic hit_v;
        hit_v     = 1'b0;
        ren_hit_s = '0;
        ren_tag_s = tag_r;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            for (int r = 1; r < NUM_ARCH_REGS; r++) begin
                hit_v        = rn_valid[i] && (rn_rd[i] == ARCH_REG_INDEX_SIZE'(r));
                ren_hit_s[r] = ren_hit_s[r] | hit_v;
                ren_tag_s[r] = hit_v ? rn_rob_id[i] : ren_tag_s[r];
            end
        end
    end

    // Post-rename, post-commit map; a commit never clears a register that is
    // being renamed again in the same cycle.
    always_comb begin
        clr_s      = commit_clear(tag_r, cm_valid, cm_rd, cm_rob_id) & ~ren_hit_s;
        map_tag_s  = ren_tag_s;
        map_busy_s = ren_hit_s | (busy_r & ~clr_s);
    end

    // Live map register: reset, then flush, then restore, then normal update.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_r  <= '0;
            busy_r <= '0;
        end else if (flush) begin
            busy_r <= '0;
        end else if (restore_s) begin
            tag_r  <= rst_tag_s;
            busy_r <= rst_busy_s;
        end else begin
            tag_r  <= map_tag_s;
            busy_r <= map_busy_s;
        end
    end

`ifdef RENAME_MAP_CKPT_EN
    tag_map_t             ck_tag_r  [NUM_CKPT];
    busy_map_t            ck_busy_r [NUM_CKPT];
    busy_map_t            ck_clr_s  [NUM_CKPT];
    logic [NUM_CKPT-1:0]  younger_r [NUM_CKPT];
    logic [NUM_CKPT-1:0]  ckv_r;
    logic [NUM_CKPT-1:0]  rel_mask_s;
    logic [NUM_CKPT-1:0]  save_mask_s;
    logic [NUM_CKPT-1:0]  kill_mask_s;
    logic [CKPT_ID_W-1:0] alloc_s;
    logic                 save_en_s;

    // Lowest-index free checkpoint slot.
    always_comb begin
        alloc_s = '0;
        for (int k = NUM_CKPT - 1; k >= 0; k--) begin
            alloc_s = ckv_r[k] ? alloc_s : CKPT_ID_W'(k);
        end
    end

    assign ckpt_free     = ~&ckv_r;
    assign ckpt_alloc_id = alloc_s;
    assign save_en_s     = ckpt_save & ckpt_free;
    assign restore_s     = ckpt_restore;

    // Slot masks, commit clearing of every copy, and the restore image.
    // younger_r[k][m] marks slot m as saved after slot k.
    always_comb begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            ck_clr_s[k]    = commit_clear(ck_tag_r[k], cm_valid, cm_rd, cm_rob_id);
            rel_mask_s[k]  = ckpt_release && (ckpt_release_id == CKPT_ID_W'(k));
            save_mask_s[k] = save_en_s && (alloc_s == CKPT_ID_W'(k));
            kill_mask_s[k] = (ckpt_restore_id == CKPT_ID_W'(k))
                             || younger_r[ckpt_restore_id][k];
        end
        rst_tag_s  = ck_tag_r[ckpt_restore_id];
        rst_busy_s = ck_busy_r[ckpt_restore_id] & ~ck_clr_s[ckpt_restore_id];
    end

    // Checkpoint storage, validity and save-order tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            ckv_r <= '0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ck_tag_r[k]  <= '0;
                ck_busy_r[k] <= '0;
                younger_r[k] <= '0;
            end
        end else if (flush) begin
            ckv_r <= '0;
        end else begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                ck_busy_r[k] <= ck_busy_r[k] & ~ck_clr_s[k];
            end
            if (ckpt_restore) begin
                ckv_r <= ckv_r & ~kill_mask_s & ~rel_mask_s;
            end else begin
                ckv_r <= (ckv_r & ~rel_mask_s) | save_mask_s;
                for (int k = 0; k < NUM_CKPT; k++) begin
                    if (save_mask_s[k]) begin
                        ck_tag_r[k]  <= map_tag_s;
                        ck_busy_r[k] <= map_busy_s;
                        younger_r[k] <= '0;
                    end
                end
                for (int k = 0; k < NUM_CKPT; k++) begin
                    for (int m = 0; m < NUM_CKPT; m++) begin
                        if (save_mask_s[m]) begin
                            younger_r[k][m] <= ckv_r[k];
                        end
                    end
                end
            end
        end
    end
`else
    logic unused_ckpt_s;

    assign unused_ckpt_s = ^{ckpt_save, ckpt_restore, ckpt_restore_id,
                             ckpt_release, ckpt_release_id};
    assign ckpt_free     = 1'b0;
    assign ckpt_alloc_id = '0;
    assign restore_s     = 1'b0;
    assign rst_tag_s     = '0;
    assign rst_busy_s    = '0;
`endif

endmodule
